otp_ctrl_seq: RTL
=================

# otp_ctrl_seq

Host-side sequencer that drives the 128x8 eFuse OTP macro pins (CSB, STROBE, LOAD, PGENB, A, VDDQ switch) and captures Q. It turns single-byte read/program requests from the register block into the macro's mode and strobe timing, with all pulse widths counted in `clk` cycles. It sits between the OTP register interface and the eFuse macro instance.

## Interface
- `T_SU`, 2, cycles from address/mode valid to STROBE rise (≥1)
- `T_HLD`, 2, cycles from STROBE fall to address/mode change (≥1)
- `T_RD_STB`, 4, read STROBE high width in cycles (≥1)
- `T_PGM_STB`, 40, program STROBE high width per bit in cycles (≥1)
- `T_VDDQ`, 8, VDDQ settle cycles after `vddq_en` rises and after it falls (≥1)
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  1  request; accepted on a rising edge where `req & ready`
- `we`  in  1  1 = program, 0 = read; sampled with `req`
- `addr`  in  7  byte address; sampled with `req`
- `wdata`  in  8  bits to blow (1 = blow); sampled with `req`
- `ready`  out  1  idle and able to accept
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  8  last read (or verify) byte; holds until next capture
- `err`  out  1  verify mismatch of last program; valid with `done`
- `otp_csb`, `otp_strobe`, `otp_load`, `otp_pgenb`  out  1 each  to macro CSB/STROBE/LOAD/PGENB
- `otp_a`  out  10  to macro A: `{addr, bit[2:0]}`
- `otp_q`  in  8  from macro Q
- `vddq_en`  out  1  enable for VDDQ power switch

## Operation
- Reset/idle levels: `otp_csb`=1, `otp_strobe`=0, `otp_load`=0, `otp_pgenb`=1, `otp_a`=0, `vddq_en`=0, `ready`=1, `done`=0, `rdata`=0, `err`=0.
- Read mode pins: CSB=0, LOAD=1, PGENB=1, `vddq_en`=0. Program mode pins: CSB=0, LOAD=0, PGENB=0, `vddq_en`=1. No other active combination is ever driven.
- States: IDLE, RD_SU, RD_STB, RD_HLD, PG_VUP, PG_SU, PG_STB, PG_HLD, PG_VDN, (VF_* when verify compiled in).
- Read: IDLE→RD_SU (T_SU, `otp_a`={addr,3'b000})→RD_STB (T_RD_STB)→RD_HLD (T_HLD; `rdata`←`otp_q` on first RD_HLD edge)→IDLE with `done`.
- Program: IDLE→PG_VUP (`vddq_en`=1, CSB=1, T_VDDQ)→for bit 0..7 with `wdata[bit]`=1 only: PG_SU (T_SU, `otp_a`={addr,bit}, program pins)→PG_STB (T_PGM_STB)→PG_HLD (T_HLD); zero bits are skipped without cycles; after last set bit CSB=1, PGENB=1 → PG_VDN (`vddq_en`=0, T_VDDQ)→IDLE with `done`.
- `wdata`=0 program: no pin activity, `done` the cycle after acceptance, `err`=0.
- `req` while `ready`=0 is ignored, not queued.
- `err` cleared on each accepted request.

## Timing
- `ready` falls the cycle after acceptance; `ready` rises with `done`.
- Read latency: `done` high in the cycle starting T_SU+T_RD_STB+T_HLD+1 edges after acceptance (9 with defaults).
- Program latency (no verify): 2·T_VDDQ + n·(T_SU+T_PGM_STB+T_HLD) + 1 edges, n = popcount(`wdata`).
- Address and mode pins stable throughout every SU/STB/HLD window; STROBE never high in any other state.
- Async reset mid-operation (including mid-strobe) forces all reset levels immediately; no request resumes.

## Configuration
- `OTP_CTRL_PGM_VERIFY_EN` defined: after PG_VDN, a full read sequence of the same byte (VF_SU/VF_STB/VF_HLD, read timing) runs before `done`; `rdata`←read-back; `err`=1 iff (`rdata` & `wdata`) ≠ `wdata`. Adds T_SU+T_RD_STB+T_HLD cycles. Applies also when `wdata`=0 is skipped? No: `wdata`=0 never verifies.
- Not defined: no verify states; `err` tied 0; `rdata` unchanged by programs.

## Test plan
- Reset, then read addr 7'h05 with macro Q=8'hA5 -> `otp_a`=10'h028, STROBE high 4 cycles, `rdata`=8'hA5, `done` 9 edges after accept.
- Program addr 7'h7F, `wdata`=8'h81 -> exactly 2 strobes of 40 cycles at `otp_a`=10'h3F8 then 10'h3FF, `vddq_en` high throughout, CSB=1 during VDDQ settle.
- Program `wdata`=8'h00 -> no STROBE/`vddq_en` activity, `done` next cycle.
- `req` pulsed during busy read -> ignored; one `done` only.
- Assert `rst_n`=0 in the middle of PG_STB -> STROBE, `vddq_en` drop and PGENB=1 same time step; `ready`=1 after release.
- With verify: program 8'h0F, model returns 8'h0E -> `err`=1, `rdata`=8'h0E; returns 8'h1F -> `err`=0.

Source files
------------

// File: rtl/otp_ctrl_seq_if.sv
// rtl/otp_ctrl_seq_if.sv - host request/response bus of the OTP eFuse sequencer
interface otp_ctrl_seq_if;
  logic       req;
  logic       we;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  modport master (output req, we, addr, wdata, input ready, done, rdata, err);
  modport slave  (input req, we, addr, wdata, output ready, done, rdata, err);
endinterface

// File: rtl/otp_ctrl_seq.sv
// rtl/otp_ctrl_seq.sv - single-byte read/program sequencer for a 128x8 eFuse OTP macro
// Define OTP_CTRL_PGM_VERIFY_EN to append a read-back verify to every non-empty program.
module otp_ctrl_seq #(
  parameter int unsigned T_SU      = 2,
  parameter int unsigned T_HLD     = 2,
  parameter int unsigned T_RD_STB  = 4,
  parameter int unsigned T_PGM_STB = 40,
  parameter int unsigned T_VDDQ    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  otp_ctrl_seq_if.slave bus,
  output logic         otp_csb,
  output logic         otp_strobe,
  output logic         otp_load,
  output logic         otp_pgenb,
  output logic [9:0]   otp_a,
  input  logic [7:0]   otp_q,
  output logic         vddq_en
);
  localparam int unsigned CW = 16;

  typedef enum logic [3:0] {
    IDLE, RD_SU, RD_STB, RD_HLD, PG_VUP, PG_SU, PG_STB, PG_HLD, PG_VDN
`ifdef OTP_CTRL_PGM_VERIFY_EN
    , VF_SU, VF_STB, VF_HLD
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    addr_q;
  logic [7:0]    mask_q, mask_d, mask_nx;
  logic [2:0]    bit_q, bit_d;
  logic          ready_q, ready_d, done_q, done_d;
  logic [7:0]    rdata_q;
  logic          accept, expire, rd_cap, rd_act, pg_act;
`ifdef OTP_CTRL_PGM_VERIFY_EN
  logic [7:0]    wdata_q;
  logic          err_q, vf_cap;
`endif

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) b = 3'(i);
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] ld(input int unsigned t);
    return CW'(t - 1);
  endfunction

  // ready_q low while state is IDLE marks the single completion cycle
  assign accept = bus.req && ready_q;
  assign expire = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = expire ? cnt_q : cnt_q - CW'(1);
    mask_d  = mask_q;
    mask_nx = mask_q & ~(8'd1 << bit_q);
    bit_d   = bit_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else if (accept) begin
          ready_d = 1'b0;
          if (!bus.we) begin
            state_d = RD_SU;
            cnt_d   = ld(T_SU);
          end else if (bus.wdata != 8'h00) begin
            state_d = PG_VUP;
            cnt_d   = ld(T_VDDQ);
            mask_d  = bus.wdata;
          end
        end
      end
      RD_SU:  if (expire) begin state_d = RD_STB; cnt_d = ld(T_RD_STB); end
      RD_STB: if (expire) begin state_d = RD_HLD; cnt_d = ld(T_HLD); end
      RD_HLD: if (expire) state_d = IDLE;
      PG_VUP: if (expire) begin
        state_d = PG_SU;
        cnt_d   = ld(T_SU);
        bit_d   = lowest_bit(mask_q);
      end
      PG_SU:  if (expire) begin state_d = PG_STB; cnt_d = ld(T_PGM_STB); end
      PG_STB: if (expire) begin state_d = PG_HLD; cnt_d = ld(T_HLD); end
      PG_HLD: if (expire) begin
        mask_d = mask_nx;
        if (mask_nx != 8'h00) begin
          state_d = PG_SU;
          cnt_d   = ld(T_SU);
          bit_d   = lowest_bit(mask_nx);
        end else begin
          state_d = PG_VDN;
          cnt_d   = ld(T_VDDQ);
        end
      end
`ifdef OTP_CTRL_PGM_VERIFY_EN
      PG_VDN: if (expire) begin state_d = VF_SU; cnt_d = ld(T_SU); end
      VF_SU:  if (expire) begin state_d = VF_STB; cnt_d = ld(T_RD_STB); end
      VF_STB: if (expire) begin state_d = VF_HLD; cnt_d = ld(T_HLD); end
      VF_HLD: if (expire) state_d = IDLE;
`else
      PG_VDN: if (expire) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Pin decode is purely from state so an async reset drops every pin at once
  always_comb begin
    rd_act     = (state_q == RD_SU) || (state_q == RD_STB) || (state_q == RD_HLD);
    pg_act     = (state_q == PG_SU) || (state_q == PG_STB) || (state_q == PG_HLD);
    otp_strobe = (state_q == RD_STB) || (state_q == PG_STB);
    rd_cap     = (state_q == RD_HLD) && (cnt_q == ld(T_HLD));
`ifdef OTP_CTRL_PGM_VERIFY_EN
    vf_cap     = (state_q == VF_HLD) && (cnt_q == ld(T_HLD));
    rd_act     = rd_act || (state_q == VF_SU) || (state_q == VF_STB) || (state_q == VF_HLD);
    otp_strobe = otp_strobe || (state_q == VF_STB);
    rd_cap     = rd_cap || vf_cap;
`endif
    otp_csb   = !(rd_act || pg_act);
    otp_load  = rd_act;
    otp_pgenb = !pg_act;
    vddq_en   = (state_q == PG_VUP) || pg_act;
    otp_a     = pg_act ? {addr_q, bit_q} : (rd_act ? {addr_q, 3'b000} : 10'h000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 7'h00;
      mask_q  <= 8'h00;
      bit_q   <= 3'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
`ifdef OTP_CTRL_PGM_VERIFY_EN
      wdata_q <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      if (accept) addr_q <= bus.addr;
      if (rd_cap) rdata_q <= otp_q;
`ifdef OTP_CTRL_PGM_VERIFY_EN
      if (accept) begin
        wdata_q <= bus.wdata;
        err_q   <= 1'b0;
      end
      if (vf_cap) err_q <= ((otp_q & wdata_q) != wdata_q);
`endif
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
`ifdef OTP_CTRL_PGM_VERIFY_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif
endmodule
